uart_receive: RTL and testbench
===============================

Name: uart_receive

Overview:
- 8N1 UART receiver, the receive-side counterpart of uart_send.
- Takes the asynchronous RXD line and synchronises it to CLK.
- Detects and validates start bits, samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Presents each received byte with a one-cycle DATA_READY pulse, the same strobe convention uart_send consumes, so top-level logic can echo or process bytes.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-low reset: sampled on the CLK rising edge, and the block is in reset while RST=0.
- RXD  input  1  serial receive line; asynchronous; idles high.
- DATA  output  8  last correctly received byte; holds until the next good byte.
- DATA_READY  output  1  one-cycle pulse when DATA has just been updated.
- FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
- IDLE  output  1  high when no frame is in progress (state IDLE).

Behaviour:
- Reset (RST=0 at a CLK edge):
  - DATA=8'h00, DATA_READY=0, FRAME_ERR=0, IDLE=1.
  - State=IDLE, counter=0, bit index=0, shift register=0.
  - Both synchroniser flops are set to 1.
  - Reset overrides all activity, including mid-frame; no pulse is ever emitted while RST=0.
- Synchroniser: two flops feed rxd_s. All decisions use rxd_s only, so there are 2 cycles of input latency.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- State IDLE:
  - IDLE=1.
  - rxd_s=0 → START, counter=0.
- State START:
  - Counter increments each cycle.
  - When counter==HALF: if rxd_s=0 → DATA_S with counter=0 and bit index=0; otherwise it was a glitch → IDLE, with no pulse.
- State DATA_S:
  - Counter increments each cycle.
  - When counter==CLKS_PER_BIT-1: sample rxd_s into shift register MSB, shifting right, so bit 0 is received first. Then counter=0 and bit index+1.
  - After the sample with bit index==7 → STOP.
- State STOP:
  - Counter counts to CLKS_PER_BIT-1, then samples rxd_s.
  - rxd_s=1: DATA ← shift register, DATA_READY=1 for exactly one cycle (the cycle after the sample edge) → IDLE.
  - rxd_s=0: FRAME_ERR=1 for one cycle, DATA unchanged → WAIT_HIGH.
- State WAIT_HIGH:
  - IDLE=0.
  - Stays here until rxd_s=1, then → IDLE.
  - This prevents a break or stuck-low line from re-triggering a start bit.
- DATA_READY and FRAME_ERR are never high in the same cycle, and each is never high for two consecutive cycles.
- Latency: DATA_READY rises HALF + 9·CLKS_PER_BIT + 5 (±1) CLK cycles after the RXD start-bit falling edge.
- Back-to-back frames: a start bit beginning immediately after the stop bit is received correctly. Return to IDLE happens at mid-stop, leaving half a bit of margin.
- Baud tolerance: correct reception for a transmitter error up to ±3 %.
- RXD is never sampled other than through the synchroniser.

Test Plan:
- Bench uses CLKS_PER_BIT=16 (HALF=7).
- Reset: hold RST=0 for 5 cycles while toggling RXD → DATA=0x00, DATA_READY=0, FRAME_ERR=0, IDLE=1 throughout. After release with RXD=1, outputs stay unchanged for 100 cycles.
- Single byte: send 0x35 ('5') as 8N1 → exactly one DATA_READY pulse at 16·9+7+5 (±1) cycles after the start edge, with DATA=0x35; IDLE=0 during the frame; FRAME_ERR never asserted.
- Back-to-back: send "0".."9" (0x30..0x39) with zero inter-frame gap → 10 DATA_READY pulses with DATA matching in order. Repeat using uart_send (CLKS_PER_BIT matched) in loopback to RXD.
- Glitch: drive RXD low for 4 cycles, then high → no state leaves IDLE for more than 8 cycles, no pulses, DATA unchanged.
- Framing error: send 0xA5 with stop bit=0, holding the line low for 40 more cycles → one FRAME_ERR pulse, no DATA_READY, DATA keeps its previous value, IDLE=0 until RXD returns high. A following valid 0x5A is then received correctly.
- Reset mid-frame: assert RST=0 at data bit 3 of 0xFF for 2 cycles, then release with RXD high → no pulse, IDLE=1. The next frame 0x39 is received correctly.

Source files
------------

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises RXD, validates the start bit at mid-bit, samples 8 data bits LSB-first
// and checks the stop bit, emitting one-cycle DATA_READY / FRAME_ERR strobes.
module uart_receive #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       DATA_READY,
  output logic       FRAME_ERR,
  output logic       IDLE
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic             rxd_m;
  logic             rxd_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [7:0]       data_nxt;
  logic             ready_nxt;
  logic             ferr_nxt;
  logic             idle_nxt;

  // Two-flop synchroniser; presets to the idle-high line level.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      DATA       <= 8'h00;
      DATA_READY <= 1'b0;
      FRAME_ERR  <= 1'b0;
      IDLE       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      DATA       <= data_nxt;
      DATA_READY <= ready_nxt;
      FRAME_ERR  <= ferr_nxt;
      IDLE       <= idle_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    case (state)
      S_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = 3'd0;
        if (!rxd_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          // A start bit that is no longer low at mid-bit is treated as a glitch.
          state_nxt   = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxd_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = rxd_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxd_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: strobes fire only on the stop-bit sample.
  always_comb begin
    data_nxt  = DATA;
    ready_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    idle_nxt  = (state_nxt == S_IDLE);
    if (state == S_STOP && cnt == LAST) begin
      if (rxd_s) begin
        data_nxt  = shreg;
        ready_nxt = 1'b1;
      end else begin
        ferr_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_uart_receive;

  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXD = 1'b1;
  logic [7:0] DATA;
  logic       DATA_READY;
  logic       FRAME_ERR;
  logic       IDLE;

  uart_receive #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXD        (RXD),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .FRAME_ERR  (FRAME_ERR),
    .IDLE       (IDLE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ready_cnt = 0;
  int         ferr_cnt = 0;
  int         last_ready_cyc = -1;
  logic       prev_pulse = 1'b0;
  logic [7:0] model_data = 8'h00;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard queue.
  always @(negedge CLK) begin
    if (DATA_READY || FRAME_ERR) begin
      check("pulse_exclusive", int'(DATA_READY & FRAME_ERR), 0);
      check("pulse_single_cycle", int'(prev_pulse), 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", int'(FRAME_ERR), int'(mon_e.ferr));
        check("pulse_data", int'(DATA), int'(mon_e.data));
      end
      if (DATA_READY) begin
        ready_cnt++;
        last_ready_cyc = cyc;
      end
      if (FRAME_ERR) ferr_cnt++;
    end
    prev_pulse = DATA_READY | FRAME_ERR;
  end

  // Drives one 8N1 frame; must be entered on a negedge and returns on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    exp_t e;
    if (stop_bit) begin
      e.ferr = 1'b0; e.data = b; model_data = b;
    end else begin
      e.ferr = 1'b1; e.data = model_data;
    end
    q.push_back(e);
    start_cyc = cyc;
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
      if (i == 3) check("idle_low_in_frame", int'(IDLE), 0);
    end
    RXD = stop_bit;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int run;
    int max_run;
    int rc0;

    // Reset held with RXD toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      RXD = ~RXD;
      check("rst_data", int'(DATA), 0);
      check("rst_ready", int'(DATA_READY), 0);
      check("rst_ferr", int'(FRAME_ERR), 0);
      check("rst_idle", int'(IDLE), 1);
    end
    RXD = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (i % 10 == 9) begin
        check("post_rst_data", int'(DATA), 0);
        check("post_rst_idle", int'(IDLE), 1);
      end
    end

    // Single byte with latency measurement.
    send_frame(8'h35, 1'b1, sc);
    drain();
    check_range("latency", last_ready_cyc - sc, 155, 157);
    check("single_ready_cnt", ready_cnt, 1);

    // Back-to-back "0".."9".
    rc0 = ready_cnt;
    for (int c = 8'h30; c <= 8'h39; c++) send_frame(8'(c), 1'b1, sc);
    RXD = 1'b1;
    drain();
    check("b2b_ready_cnt", ready_cnt - rc0, 10);

    // Glitch shorter than half a bit.
    repeat (20) @(negedge CLK);
    RXD = 1'b0;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      run = IDLE ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    check_range("glitch_idle_low_run", max_run, 1, 8);
    check("glitch_data_hold", int'(DATA), int'(model_data));

    // Framing error followed by a held-low line, then a good frame.
    send_frame(8'hA5, 1'b0, sc);
    repeat (40) @(negedge CLK);
    check("ferr_wait_high_idle", int'(IDLE), 0);
    check("ferr_data_hold", int'(DATA), 8'h39);
    RXD = 1'b1;
    repeat (5) @(negedge CLK);
    check("ferr_back_to_idle", int'(IDLE), 1);
    send_frame(8'h5A, 1'b1, sc);
    RXD = 1'b1;
    drain();

    // Reset in the middle of data bit 3 of 0xFF.
    repeat (10) @(negedge CLK);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (CPB * 3 + 8) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    model_data = 8'h00;
    repeat (200) @(negedge CLK);
    check("midrst_idle", int'(IDLE), 1);
    check("midrst_data", int'(DATA), 0);
    send_frame(8'h39, 1'b1, sc);
    RXD = 1'b1;
    drain();

    check("total_ready_cnt", ready_cnt, 13);
    check("total_ferr_cnt", ferr_cnt, 1);
    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
